alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the 16-bit combinational ALU.
- Adds valid/ready handshakes with backpressure, a retired-flags register and a lane-wise saturating add (PADDSB).
- Sits between decode/register-read and writeback in the execute stage.

---
 rtl/alu_pipe.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined execute ALU with valid/ready handshakes, saturating ADD/SUB,
// lane-wise saturating add (PADDSB) and a flags register that updates on retirement.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic [2:0]       out_flags
);

  localparam int NLANE = WIDTH / LANE;
  localparam int LW    = LANE + 1;
  localparam int SHW   = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  // A raw sum one bit wider than the operands overflows when its top two bits differ;
  // the top bit then carries the true sign and picks the saturation rail.
  function automatic logic [WIDTH-1:0] sat_word(input logic [WIDTH:0] raw);
    if (raw[WIDTH] != raw[WIDTH-1]) begin
      sat_word = raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_word = raw[WIDTH-1:0];
    end
  endfunction

  function automatic logic [LANE-1:0] sat_lane(input logic [LANE:0] raw);
    if (raw[LANE] != raw[LANE-1]) begin
      sat_lane = raw[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
    end else begin
      sat_lane = raw[LANE-1:0];
    end
  endfunction

  logic                 s1_valid_r;
  logic [3:0]           s1_op_r;
  logic [WIDTH:0]       s1_sum_r;
  logic [NLANE*LW-1:0]  s1_lane_r;
  logic [WIDTH-1:0]     s1_logic_r;

  logic                 s2_valid_r;
  logic [WIDTH-1:0]     s2_result_r;
  logic                 s2_illegal_r;
  logic                 s2_vn_upd_r;
  logic                 s2_v_cand_r;
  logic [2:0]           flags_r;

  logic                 s2_free_s;
  logic [WIDTH:0]       a_ext_s;
  logic [WIDTH:0]       b_ext_s;
  logic [WIDTH:0]       sum_s;
  logic [NLANE*LW-1:0]  lane_s;
  logic [SHW-1:0]       shamt_s;
  logic [2*WIDTH-1:0]   rot_s;
  logic [WIDTH-1:0]     logic_s;
  logic [WIDTH-1:0]     res_s;
  logic                 illegal_s;
  logic                 vn_upd_s;
  logic                 v_cand_s;

  assign s2_free_s   = !s2_valid_r || out_ready;
  assign in_ready    = !s1_valid_r || s2_free_s;
  assign out_valid   = s2_valid_r;
  assign out_result  = s2_result_r;
  assign out_illegal = s2_illegal_r;
  assign out_flags   = flags_r;

  // Stage 1 datapath: raw add/sub, per-lane raw sums, shift and logic results.
  always_comb begin
    a_ext_s = {in_a[WIDTH-1], in_a};
    b_ext_s = {in_b[WIDTH-1], in_b};
    if (in_op == OP_SUB) begin
      sum_s = a_ext_s - b_ext_s;
    end else begin
      sum_s = a_ext_s + b_ext_s;
    end
    for (int i = 0; i < NLANE; i++) begin
      lane_s[i*LW +: LW] = {in_a[i*LANE+LANE-1], in_a[i*LANE +: LANE]}
                         + {in_b[i*LANE+LANE-1], in_b[i*LANE +: LANE]};
    end
    shamt_s = in_b[SHW-1:0];
    rot_s   = {in_a, in_a} >> shamt_s;
    case (in_op)
      OP_XOR:  logic_s = in_a ^ in_b;
      OP_AND:  logic_s = in_a & in_b;
      OP_SLL:  logic_s = in_a << shamt_s;
      OP_SRA:  logic_s = $signed(in_a) >>> shamt_s;
      OP_ROR:  logic_s = rot_s[WIDTH-1:0];
      default: logic_s = {WIDTH{1'b0}};
    endcase
  end

  // Stage 1 register: loads whenever the stage is empty or draining into stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'b0000;
      s1_sum_r   <= {(WIDTH+1){1'b0}};
      s1_lane_r  <= {(NLANE*LW){1'b0}};
      s1_logic_r <= {WIDTH{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r    <= in_op;
        s1_sum_r   <= sum_s;
        s1_lane_r  <= lane_s;
        s1_logic_r <= logic_s;
      end
    end
  end

  // Stage 2 datapath: saturation, illegal marking and flag candidates.
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    illegal_s = 1'b0;
    vn_upd_s  = 1'b0;
    v_cand_s  = 1'b0;
    case (s1_op_r)
      OP_ADD, OP_SUB: begin
        res_s    = sat_word(s1_sum_r);
        v_cand_s = s1_sum_r[WIDTH] ^ s1_sum_r[WIDTH-1];
        vn_upd_s = 1'b1;
      end
      OP_XOR, OP_AND, OP_SLL, OP_SRA, OP_ROR: begin
        res_s = s1_logic_r;
      end
      OP_PADDSB: begin
        for (int i = 0; i < NLANE; i++) begin
          res_s[i*LANE +: LANE] = sat_lane(s1_lane_r[i*LW +: LW]);
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Stage 2 register: output data holds while a presented result is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_result_r  <= {WIDTH{1'b0}};
      s2_illegal_r <= 1'b0;
      s2_vn_upd_r  <= 1'b0;
      s2_v_cand_r  <= 1'b0;
    end else if (s2_free_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r  <= res_s;
        s2_illegal_r <= illegal_s;
        s2_vn_upd_r  <= vn_upd_s;
        s2_v_cand_r  <= v_cand_s;
      end
    end
  end

  // Retired-flags register {Z,V,N}: illegal ops leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 3'b000;
    end else if (s2_valid_r && out_ready && !s2_illegal_r) begin
      flags_r[2] <= (s2_result_r == {WIDTH{1'b0}});
      if (s2_vn_upd_r) begin
        flags_r[1] <= s2_v_cand_r;
        flags_r[0] <= s2_result_r[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: each step drives one operation or
// handshake pattern and checks outputs against hand-computed values.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_illegal;
  logic [2:0]  out_flags;

  int tests_run = 0;
  int fail_cnt  = 0;

  alu_pipe #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One op through an unstalled pipe: accept, present after one more edge, retire.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic ei,
                       input logic [2:0] ef);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    check({tag, " s1 out_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, 32'(out_result), 32'(er));
    check({tag, " illegal"}, 32'(out_illegal), 32'(ei));
    tick();
    check({tag, " flags"}, 32'(out_flags), 32'(ef));
    check({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = 16'h0000; in_b = 16'h0000;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(out_result), 32'd0);
    check("rst illegal", 32'(out_illegal), 32'd0);
    check("rst flags", 32'(out_flags), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    do_op("add_sat_pos", 4'h0, 16'h7FFF, 16'h0123, 16'h7FFF, 1'b0, 3'b010);
    do_op("sub_sat_neg", 4'h1, 16'h8000, 16'h0010, 16'h8000, 1'b0, 3'b011);
    do_op("paddsb", 4'h7, 16'h7321, 16'h1F1F, 16'h7230, 1'b0, 3'b011);
    do_op("sub_plain", 4'h1, 16'h1234, 16'h0123, 16'h1111, 1'b0, 3'b000);
    do_op("xor_zero", 4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b100);
    do_op("sub_sat_neg2", 4'h1, 16'h8000, 16'h0010, 16'h8000, 1'b0, 3'b011);
    do_op("xor_zero_keep_vn", 4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b111);
    do_op("sra_upper_ignored", 4'h5, 16'h8000, 16'h0013, 16'hF000, 1'b0, 3'b011);
    do_op("and", 4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 3'b011);
    do_op("sll_by_zero", 4'h4, 16'h1234, 16'h0010, 16'h1234, 1'b0, 3'b011);
    do_op("ror_by_zero", 4'h6, 16'hA5C3, 16'h0000, 16'hA5C3, 1'b0, 3'b011);
    do_op("add_sat_neg", 4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 3'b011);
    do_op("illegal_f", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b1, 3'b011);

    // Backpressure: two accepts fill the pipe, third op waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_a = 16'h1234; in_b = 16'h0122;
    tick();
    check("bp in_ready after 1", 32'(in_ready), 32'd1);
    in_op = 4'h4; in_a = 16'h0001; in_b = 16'h0004;
    tick();
    check("bp in_ready full", 32'(in_ready), 32'd0);
    check("bp out_valid", 32'(out_valid), 32'd1);
    check("bp result0", 32'(out_result), 32'h1356);
    in_op = 4'h6; in_a = 16'h0001; in_b = 16'h0001;
    tick();
    check("bp hold ready", 32'(in_ready), 32'd0);
    check("bp hold valid", 32'(out_valid), 32'd1);
    check("bp hold result", 32'(out_result), 32'h1356);
    tick();
    check("bp hold2 result", 32'(out_result), 32'h1356);
    check("bp hold2 illegal", 32'(out_illegal), 32'd0);
    check("bp flags unretired", 32'(out_flags), 32'b011);
    out_ready = 1'b1;
    #1;
    check("bp ready rises", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp retire1 flags", 32'(out_flags), 32'b000);
    check("bp r1 valid", 32'(out_valid), 32'd1);
    check("bp r1 result", 32'(out_result), 32'h0010);
    tick();
    check("bp r2 valid", 32'(out_valid), 32'd1);
    check("bp r2 result", 32'(out_result), 32'h8000);
    tick();
    check("bp drained", 32'(out_valid), 32'd0);
    check("bp final flags", 32'(out_flags), 32'b000);

    // Reset with two ops in flight.
    do_op("sub_sat_pre_rst", 4'h1, 16'h8000, 16'h0010, 16'h8000, 1'b0, 3'b011);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_a = 16'h0001; in_b = 16'h0001;
    tick();
    in_op = 4'h1; in_a = 16'h0005; in_b = 16'h0003;
    tick();
    check("inflight result", 32'(out_result), 32'h0002);
    rst = 1'b1; out_ready = 1'b1; in_op = 4'h2; in_a = 16'h0000; in_b = 16'h0000;
    tick();
    rst = 1'b0;
    check("rst2 out_valid", 32'(out_valid), 32'd0);
    check("rst2 flags", 32'(out_flags), 32'd0);
    check("rst2 result", 32'(out_result), 32'd0);
    check("rst2 in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = 4'h0; in_a = 16'h0003; in_b = 16'h0004;
    tick();
    in_valid = 1'b0;
    check("post_rst no ghost", 32'(out_valid), 32'd0);
    tick();
    check("post_rst valid", 32'(out_valid), 32'd1);
    check("post_rst result", 32'(out_result), 32'h0007);
    tick();
    check("post_rst flags", 32'(out_flags), 32'b000);
    check("post_rst drained", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
